// File: rtl/scatter_trig_core.sv
// -----------------------------------------------------------------------------
// scatter_trig_core
//   Cosmic scatter trigger for two bar walls. The chain is:
//   input masking, per-channel pulse stretching, sliding-window ORs per wall,
//   mode selection, and a prescaled, dead-timed trigger FSM that drives a
//   1-cycle trigger pulse and a fixed-length MQDC gate.
//
// Ports:
//   CLK_PCLK_RIGHT  in   200 MHz trigger clock
//   RESET_N         in   asynchronous active-low reset
//   INP             in   bar discriminator inputs (left wall in the low bits)
//   trig_mask       in   per-channel enable (1 = enabled)
//   mode            in   0: L|R, 1: L, 2: R, 3: L&R
//   prescale        in   accept 1 of every N candidates (0 behaves as 1)
//   trig_out        out  1-cycle pulse per accepted trigger
//   gate_out        out  MQDC gate, GATE_LEN cycles
//   busy            out  high while in GATE or HOLD
//   accept_cnt      out  accepted-trigger count (wraps)
//   rate_left/right out  rising-edge counts of L and R
//                        (only when SCATTER_TRIG_RATE_CNT_EN is defined)
//
// Optional feature macro: SCATTER_TRIG_RATE_CNT_EN
// -----------------------------------------------------------------------------
module scatter_trig_core #(
  parameter int N_LEFT   = 18,
  parameter int N_RIGHT  = 28,
  parameter int WIN      = 6,
  parameter int STRETCH  = 6,
  parameter int GATE_LEN = 20,
  parameter int HOLDOFF  = 10,
  parameter int PS_W     = 16
) (
  input  logic                        CLK_PCLK_RIGHT,
  input  logic                        RESET_N,
  input  logic [N_LEFT+N_RIGHT-1:0]   INP,
  input  logic [N_LEFT+N_RIGHT-1:0]   trig_mask,
  input  logic [1:0]                  mode,
  input  logic [PS_W-1:0]             prescale,
  output logic                        trig_out,
  output logic                        gate_out,
  output logic                        busy,
  output logic [31:0]                 accept_cnt
`ifdef SCATTER_TRIG_RATE_CNT_EN
  ,
  output logic [31:0]                 rate_left,
  output logic [31:0]                 rate_right
`endif
);

  // State  | meaning
  // IDLE   | waiting for a candidate rising edge, prescaler active
  // GATE   | gate_out asserted, GATE_LEN cycles
  // HOLD   | dead time after the gate, HOLDOFF cycles
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int N = N_LEFT + N_RIGHT;
  localparam int NWL = N_LEFT - WIN + 1;
  localparam int NWR = N_RIGHT - WIN + 1;
  localparam logic [5:0] STR_LD  = 6'(STRETCH);
  localparam logic [7:0] GATE_LD = 8'(GATE_LEN - 1);
  localparam logic [7:0] HOLD_LD = 8'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);
  localparam bit HOLD_EN = (HOLDOFF != 0);

  // Stage 1: masked input sample, plus its previous value for edge detect
  logic [N-1:0] in_q;
  logic [N-1:0] in_d;
  logic [N-1:0] in_rise;

  always_ff @(posedge CLK_PCLK_RIGHT or negedge RESET_N) begin
    if (!RESET_N) begin
      in_q <= '0;
      in_d <= '0;
    end else begin
      in_q <= INP & trig_mask;
      in_d <= in_q;
    end
  end

  assign in_rise = in_q & ~in_d;

  // Stage 2: per-channel retriggerable stretch counters
  logic [5:0]   str_cnt [N];
  logic [N-1:0] str;

  always_ff @(posedge CLK_PCLK_RIGHT or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < N; i++) str_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_rise[i])
          str_cnt[i] <= STR_LD;
        else if (str_cnt[i] != 6'd0)
          str_cnt[i] <= str_cnt[i] - 6'd1;
      end
    end
  end

  always_comb begin
    str = '0;
    for (int i = 0; i < N; i++) str[i] = (str_cnt[i] != 6'd0);
  end

  // Sliding windows, kept within their own wall
  logic [NWL-1:0] win_l;
  logic [NWR-1:0] win_r;
  logic           l_or;
  logic           r_or;

  for (genvar j = 0; j < NWL; j++) begin : g_win_l
    assign win_l[j] = |str[j +: WIN];
  end

  for (genvar j = 0; j < NWR; j++) begin : g_win_r
    assign win_r[j] = |str[N_LEFT + j +: WIN];
  end

  assign l_or = |win_l;
  assign r_or = |win_r;

  // Stage 3: mode selection and candidate edge
  logic cand_sel;
  logic cand_q;
  logic cand_d;
  logic cand_rise;

  always_comb begin
    cand_sel = 1'b0;
    case (mode)
      2'd0:    cand_sel = l_or | r_or;
      2'd1:    cand_sel = l_or;
      2'd2:    cand_sel = r_or;
      default: cand_sel = l_or & r_or;
    endcase
  end

  always_ff @(posedge CLK_PCLK_RIGHT or negedge RESET_N) begin
    if (!RESET_N) begin
      cand_q <= 1'b0;
      cand_d <= 1'b0;
    end else begin
      cand_q <= cand_sel;
      cand_d <= cand_q;
    end
  end

  assign cand_rise = cand_q & ~cand_d;

  // Trigger FSM
  state_t          state;
  state_t          state_n;
  logic [7:0]      timer;
  logic [7:0]      timer_n;
  logic [PS_W-1:0] ps_cnt;
  logic [PS_W-1:0] ps_n;
  logic            trig_n;
  logic [31:0]     acc_n;
  logic [PS_W:0]   ps_next;
  logic [PS_W:0]   ps_thr;

  // Widened by one bit so ps_cnt+1 never wraps before the compare
  assign ps_next = {1'b0, ps_cnt} + {{PS_W{1'b0}}, 1'b1};
  assign ps_thr  = (prescale == '0) ? {{PS_W{1'b0}}, 1'b1} : {1'b0, prescale};

  always_ff @(posedge CLK_PCLK_RIGHT or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      timer      <= '0;
      ps_cnt     <= '0;
      trig_out   <= 1'b0;
      accept_cnt <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      ps_cnt     <= ps_n;
      trig_out   <= trig_n;
      accept_cnt <= acc_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    ps_n    = ps_cnt;
    trig_n  = 1'b0;
    acc_n   = accept_cnt;
    case (state)
      IDLE: begin
        if (cand_rise) begin
          if (ps_next >= ps_thr) begin
            ps_n    = '0;
            state_n = GATE;
            timer_n = GATE_LD;
            trig_n  = 1'b1;
            acc_n   = accept_cnt + 32'd1;
          end else begin
            ps_n = ps_next[PS_W-1:0];
          end
        end
      end
      GATE: begin
        if (timer == 8'd0) begin
          if (HOLD_EN) begin
            state_n = HOLD;
            timer_n = HOLD_LD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          timer_n = timer - 8'd1;
        end
      end
      HOLD: begin
        if (timer == 8'd0)
          state_n = IDLE;
        else
          timer_n = timer - 8'd1;
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  // Decoded from state so both drop as soon as reset asserts
  assign gate_out = (state == GATE);
  assign busy     = (state == GATE) || (state == HOLD);

`ifdef SCATTER_TRIG_RATE_CNT_EN
  logic l_d;
  logic r_d;

  always_ff @(posedge CLK_PCLK_RIGHT or negedge RESET_N) begin
    if (!RESET_N) begin
      l_d        <= 1'b0;
      r_d        <= 1'b0;
      rate_left  <= '0;
      rate_right <= '0;
    end else begin
      l_d <= l_or;
      r_d <= r_or;
      if (l_or && !l_d) rate_left  <= rate_left + 32'd1;
      if (r_or && !r_d) rate_right <= rate_right + 32'd1;
    end
  end
`endif

endmodule
